// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the Ethernet/IPv4/UDP receive parser.
package udp_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ETH_HDR,
    ST_IP_HDR,
    ST_UDP_HDR,
    ST_PAYLOAD,
    ST_TRAIL,
    ST_DROP
  } state_e;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  localparam int unsigned ETH_HDR_LEN  = 14;
  localparam int unsigned IP_HDR_LEN   = 20;
  localparam int unsigned UDP_HDR_LEN  = 8;
  localparam int unsigned MAX_PREAMBLE = 7;
  localparam int unsigned MIN_TRAIL    = 4;

  // One byte of reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-parallel reflected CRC-32 register with synchronous init and enable.
module crc32_d8
  import udp_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = '1;
    end else if (en_i) begin
      crc_d = crc32_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '1;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/udp_rx_parser.sv
// GMII Ethernet/IPv4/UDP receive parser: filters on MAC/IP/port, streams payload, FCS verdict.
// Define IP_CSUM_CHECK_EN to also drop frames whose IPv4 header checksum is wrong.
module udp_rx_parser
  import udp_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h112233445566,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80180,
  parameter logic [15:0] LOCAL_PORT = 16'd1234,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  input  logic [7:0]       gmii_rxd,
  output logic [7:0]       udp_data,
  output logic             udp_valid,
  output logic             udp_sof,
  output logic             udp_eof,
  output logic [15:0]      udp_len,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [CNT_W-1:0] drop_cnt
);

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [39:0]      sh_q, sh_d;
  logic [15:0]      len_q, len_d;
  logic             err_q, err_d;
  logic             sof_seen_q, sof_seen_d;
  logic             dv_q;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic [15:0]      ulen_q, ulen_d;
  logic             done_q, done_d, ok_q, ok_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             drop_inc_c, crc_init_c, crc_en_c, last_pay_c, crc_ok_c, csum_bad_c;
  logic [15:0]      hdr_word_c;
  logic [31:0]      crc;

  assign hdr_word_c = {sh_q[7:0], gmii_rxd};
  assign crc_ok_c   = (crc == CRC_RESIDUE);
  assign last_pay_c = (cnt_q == len_q - 16'd1);

  crc32_d8 u_crc (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .init_i (crc_init_c),
    .en_i   (crc_en_c),
    .data_i (gmii_rxd),
    .crc_o  (crc)
  );

`ifdef IP_CSUM_CHECK_EN
  logic [15:0] sum_q, sum_d;
  logic [16:0] sum_add_c;

  // Ones-complement sum of the IPv4 header words with end-around carry.
  always_comb begin
    sum_add_c = 17'(sum_q) + 17'(hdr_word_c);
    sum_d     = sum_q;
    if (state_q != ST_IP_HDR) begin
      sum_d = '0;
    end else if (cnt_q[0]) begin
      sum_d = sum_add_c[15:0] + 16'(sum_add_c[16]);
    end
  end

  assign csum_bad_c = (sum_d != 16'hFFFF);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sum_q <= '0;
    else            sum_q <= sum_d;
  end
`else
  assign csum_bad_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    sh_d       = {sh_q[31:0], gmii_rxd};
    len_d      = len_q;
    err_d      = err_q;
    sof_seen_d = sof_seen_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    ulen_d     = ulen_q;
    done_d     = 1'b0;
    ok_d       = 1'b0;
    drop_inc_c = 1'b0;
    crc_init_c = 1'b0;
    crc_en_c   = 1'b0;

    case (state_q)
      // A frame starts only on a dv rising edge, so frame tails after reset are ignored.
      ST_IDLE: begin
        crc_init_c = 1'b1;
        cnt_d      = 16'd1;
        err_d      = 1'b0;
        sof_seen_d = 1'b0;
        if (gmii_rx_dv && !dv_q && gmii_rxd == PREAMBLE_BYTE) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        crc_init_c = 1'b1;
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
        end else if (gmii_rx_er) begin
          state_d = ST_DROP;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_d = ST_ETH_HDR;
          cnt_d   = '0;
        end else if (gmii_rxd != PREAMBLE_BYTE || cnt_q >= 16'(MAX_PREAMBLE)) begin
          state_d = ST_DROP;
        end
      end
      ST_ETH_HDR: begin
        crc_en_c = gmii_rx_dv;
        if (!gmii_rx_dv) begin
          drop_inc_c = 1'b1;
          state_d    = ST_IDLE;
        end else if (gmii_rx_er) begin
          state_d = ST_DROP;
        end else if (cnt_q == 16'd5 && {sh_q, gmii_rxd} != LOCAL_MAC) begin
          state_d = ST_DROP;
        end else if (cnt_q == 16'(ETH_HDR_LEN - 1)) begin
          state_d = (hdr_word_c == ETH_TYPE_IPV4) ? ST_IP_HDR : ST_DROP;
          cnt_d   = '0;
        end
      end
      ST_IP_HDR: begin
        crc_en_c = gmii_rx_dv;
        if (!gmii_rx_dv) begin
          drop_inc_c = 1'b1;
          state_d    = ST_IDLE;
        end else if (gmii_rx_er) begin
          state_d = ST_DROP;
        end else if (cnt_q == 16'd0 && gmii_rxd != IP_VER_IHL) begin
          state_d = ST_DROP;
        end else if (cnt_q == 16'd9 && gmii_rxd != IP_PROTO_UDP) begin
          state_d = ST_DROP;
        end else if (cnt_q == 16'(IP_HDR_LEN - 1)) begin
          state_d = ({sh_q[23:0], gmii_rxd} == LOCAL_IP && !csum_bad_c) ? ST_UDP_HDR : ST_DROP;
          cnt_d   = '0;
        end
      end
      ST_UDP_HDR: begin
        crc_en_c = gmii_rx_dv;
        if (!gmii_rx_dv) begin
          drop_inc_c = 1'b1;
          state_d    = ST_IDLE;
        end else if (gmii_rx_er) begin
          state_d = ST_DROP;
        end else if (cnt_q == 16'd3 && hdr_word_c != LOCAL_PORT) begin
          state_d = ST_DROP;
        end else if (cnt_q == 16'd5) begin
          if (hdr_word_c < 16'(UDP_HDR_LEN)) state_d = ST_DROP;
          len_d = hdr_word_c - 16'(UDP_HDR_LEN);
        end else if (cnt_q == 16'(UDP_HDR_LEN - 1)) begin
          cnt_d   = '0;
          state_d = (len_q == 16'd0) ? ST_TRAIL : ST_PAYLOAD;
          if (len_q != 16'd0) ulen_d = len_q;
        end
      end
      ST_PAYLOAD: begin
        crc_en_c = gmii_rx_dv;
        if (!gmii_rx_dv) begin
          done_d     = 1'b1;
          drop_inc_c = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          valid_d    = 1'b1;
          data_d     = gmii_rxd;
          sof_d      = (cnt_q == 16'd0);
          eof_d      = last_pay_c;
          sof_seen_d = 1'b1;
          if (gmii_rx_er) err_d = 1'b1;
          if (last_pay_c) begin
            state_d = ST_TRAIL;
            cnt_d   = '0;
          end
        end
      end
      // Pad and FCS; the count only needs to prove the FCS was present.
      ST_TRAIL: begin
        crc_en_c = gmii_rx_dv;
        if (gmii_rx_dv) begin
          if (gmii_rx_er) err_d = 1'b1;
          cnt_d = (cnt_q < 16'(MIN_TRAIL)) ? cnt_q + 16'd1 : cnt_q;
        end else begin
          state_d = ST_IDLE;
          if (sof_seen_q) begin
            done_d     = 1'b1;
            ok_d       = crc_ok_c && !err_q && (cnt_q >= 16'(MIN_TRAIL));
            drop_inc_c = !ok_d;
          end
        end
      end
      ST_DROP: begin
        if (!gmii_rx_dv) begin
          drop_inc_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    drop_d = (drop_inc_c && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      sof_seen_q <= 1'b0;
      dv_q       <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ulen_q     <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      len_q      <= len_d;
      err_q      <= err_d;
      sof_seen_q <= sof_seen_d;
      dv_q       <= gmii_rx_dv;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      ulen_q     <= ulen_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
    end
  end

  assign udp_data  = data_q;
  assign udp_valid = valid_q;
  assign udp_sof   = sof_q;
  assign udp_eof   = eof_q;
  assign udp_len   = ulen_q;
  assign pkt_done  = done_q;
  assign pkt_ok    = ok_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Scoreboard bench for udp_rx_parser: directed frames, monitor pops expected payload/verdict events.
module tb_udp_rx_parser;

  localparam int unsigned CNT_W = 3;
  localparam logic [47:0] LMAC  = 48'h112233445566;
  localparam logic [31:0] LIP   = 32'hC0A80180;
  localparam logic [15:0] LPORT = 16'd1234;
  localparam int          PAY0  = 42;

  logic             sys_clk    = 1'b0;
  logic             sys_rst_n  = 1'b0;
  logic             gmii_rx_dv = 1'b0;
  logic             gmii_rx_er = 1'b0;
  logic [7:0]       gmii_rxd   = 8'h00;
  logic [7:0]       udp_data;
  logic             udp_valid, udp_sof, udp_eof, pkt_done, pkt_ok;
  logic [15:0]      udp_len;
  logic [CNT_W-1:0] drop_cnt;

  udp_rx_parser #(
    .LOCAL_MAC  (LMAC),
    .LOCAL_IP   (LIP),
    .LOCAL_PORT (LPORT),
    .CNT_W      (CNT_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .gmii_rxd   (gmii_rxd),
    .udp_data   (udp_data),
    .udp_valid  (udp_valid),
    .udp_sof    (udp_sof),
    .udp_eof    (udp_eof),
    .udp_len    (udp_len),
    .pkt_done   (pkt_done),
    .pkt_ok     (pkt_ok),
    .drop_cnt   (drop_cnt)
  );

  always #4 sys_clk = ~sys_clk;

  typedef struct {
    bit          done;
    logic [7:0]  data;
    bit          sof;
    bit          eof;
    logic [15:0] len;
    bit          ok;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] frm[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Ethernet frame from dest MAC through FCS; payload byte i is i mod 256.
  task automatic build(input logic [47:0] mac, input logic [15:0] etype, input logic [31:0] ip,
                       input logic [15:0] port, input int plen, input int ulen);
    logic [7:0]  iph [20];
    logic [31:0] sum;
    logic [31:0] crc;
    logic [15:0] tot;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [15:0] ul;
    logic [31:0] fcs;
    smac = 48'h020000000001;
    sip  = 32'hC0A80101;
    tot  = 16'(28 + plen);
    ul   = 16'(ulen);
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(mac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(smac[8*i +: 8]);
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    iph = '{8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, sip[31:24], sip[23:16], sip[15:8], sip[7:0],
            ip[31:24], ip[23:16], ip[15:8], ip[7:0]};
    sum = 32'h0;
    for (int i = 0; i < 20; i += 2) sum = sum + {16'h0, iph[i], iph[i+1]};
    while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = ~sum;
    iph[10] = sum[15:8];
    iph[11] = sum[7:0];
    for (int i = 0; i < 20; i++) frm.push_back(iph[i]);
    frm.push_back(8'h13);
    frm.push_back(8'h88);
    frm.push_back(port[15:8]);
    frm.push_back(port[7:0]);
    frm.push_back(ul[15:8]);
    frm.push_back(ul[7:0]);
    frm.push_back(8'h00);
    frm.push_back(8'h00);
    for (int i = 0; i < plen; i++) frm.push_back(8'(i));
    while (frm.size() < 60) frm.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    foreach (frm[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (frm[k][b] ^ crc[0]) crc = (crc >> 1) ^ 32'hEDB88320;
        else                    crc = crc >> 1;
      end
    end
    fcs = ~crc;
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
  endtask

  task automatic exp_pay(input int n, input int plen);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.done = 1'b0;
      e.data = frm[PAY0 + i];
      e.sof  = (i == 0);
      e.eof  = (i == plen - 1);
      e.len  = 16'(plen);
      e.ok   = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic exp_done(input bit ok);
    exp_t e;
    e.done = 1'b1;
    e.data = 8'h00;
    e.sof  = 1'b0;
    e.eof  = 1'b0;
    e.len  = 16'h0;
    e.ok   = ok;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] b, input bit er);
    @(posedge sys_clk);
    #1;
    sys_rst_n  = 1'b1;
    gmii_rx_dv = 1'b1;
    gmii_rxd   = b;
    gmii_rx_er = er;
  endtask

  // cut: frame bytes to send (-1 all); er_at/rst_at: frame byte index for rx_er / reset pulse.
  task automatic send(input int cut, input int er_at, input int rst_at, input bit nopre);
    int n;
    n = (cut < 0) ? frm.size() : cut;
    if (!nopre) begin
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
      drive(8'hD5, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      drive(frm[i], i == er_at);
      if (i == rst_at) begin
        #5;
        sys_rst_n = 1'b0;
        #1;
        check("rst_udp_valid", 48'(udp_valid), 48'd0);
        check("rst_udp_len", 48'(udp_len), 48'd0);
        check("rst_drop_cnt", 48'(drop_cnt), 48'd0);
        check("rst_pkt_done", 48'(pkt_done), 48'd0);
      end
    end
    @(posedge sys_clk);
    #1;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  // Monitor: every payload strobe and verdict must match the head of the expected queue.
  always @(negedge sys_clk) begin
    if (udp_valid) begin
      if (exp_q.size() == 0 || exp_q[0].done) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_udp_valid: got data %0h expected no strobe at %0t", udp_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("udp_data", 48'(udp_data), 48'(mon_e.data));
        check("udp_sof", 48'(udp_sof), 48'(mon_e.sof));
        check("udp_eof", 48'(udp_eof), 48'(mon_e.eof));
        if (mon_e.sof) check("udp_len", 48'(udp_len), 48'(mon_e.len));
      end
    end
    if (pkt_done) begin
      if (exp_q.size() == 0 || !exp_q[0].done) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pkt_done: got pkt_ok %0b expected no pkt_done at %0t", pkt_ok, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pkt_ok", 48'(pkt_ok), 48'(mon_e.ok));
      end
    end
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_udp_valid", 48'(udp_valid), 48'd0);
    check("reset_udp_sof", 48'(udp_sof), 48'd0);
    check("reset_udp_eof", 48'(udp_eof), 48'd0);
    check("reset_udp_data", 48'(udp_data), 48'd0);
    check("reset_udp_len", 48'(udp_len), 48'd0);
    check("reset_pkt_done", 48'(pkt_done), 48'd0);
    check("reset_pkt_ok", 48'(pkt_ok), 48'd0);
    check("reset_drop_cnt", 48'(drop_cnt), 48'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;

    build(LMAC, 16'h0800, LIP, LPORT, 512, 520);
    exp_pay(512, 512); exp_done(1'b1);
    send(-1, -1, -1, 1'b0);
    check("drop_good512", 48'(drop_cnt), 48'd0);

    build(LMAC, 16'h0800, LIP, LPORT, 3, 11);
    exp_pay(3, 3); exp_done(1'b1);
    send(-1, -1, -1, 1'b0);
    check("drop_short_pad", 48'(drop_cnt), 48'd0);
    check("len_held_short", 48'(udp_len), 48'd3);

    build(LMAC, 16'h0800, LIP, LPORT, 64, 72);
    frm[PAY0 + 10] = frm[PAY0 + 10] ^ 8'hFF;
    exp_pay(64, 64); exp_done(1'b0);
    send(-1, -1, -1, 1'b0);
    check("drop_bad_fcs", 48'(drop_cnt), 48'd1);

    build(48'hFFFFFFFFFFFF, 16'h0806, LIP, LPORT, 28, 36);
    send(-1, -1, -1, 1'b0);
    check("drop_arp_bcast", 48'(drop_cnt), 48'd2);
    build(LMAC, 16'h0800, 32'hC0A80181, LPORT, 16, 24);
    send(-1, -1, -1, 1'b0);
    check("drop_wrong_ip", 48'(drop_cnt), 48'd3);

    build(LMAC, 16'h0800, LIP, LPORT, 512, 520);
    exp_pay(100, 512); exp_done(1'b0);
    send(PAY0 + 100, -1, -1, 1'b0);
    check("drop_truncated", 48'(drop_cnt), 48'd4);
    build(LMAC, 16'h0800, LIP, LPORT, 20, 28);
    exp_pay(20, 20); exp_done(1'b1);
    send(-1, -1, -1, 1'b0);
    check("drop_after_trunc", 48'(drop_cnt), 48'd4);

    build(LMAC, 16'h0800, LIP, LPORT, 16, 24);
    exp_pay(16, 16); exp_done(1'b0);
    send(-1, PAY0 + 5, -1, 1'b0);
    check("drop_er_payload", 48'(drop_cnt), 48'd5);
    send(-1, 20, -1, 1'b0);
    check("drop_er_header", 48'(drop_cnt), 48'd6);
    send(-1, -1, -1, 1'b1);
    check("drop_no_preamble", 48'(drop_cnt), 48'd6);

    build(LMAC, 16'h0806, LIP, LPORT, 16, 24);
    send(-1, -1, -1, 1'b0);
    check("drop_ethertype", 48'(drop_cnt), 48'd7);
    build(LMAC, 16'h0800, LIP, LPORT, 16, 4);
    send(-1, -1, -1, 1'b0);
    check("drop_saturated", 48'(drop_cnt), 48'd7);

    build(LMAC, 16'h0800, LIP, LPORT, 512, 520);
    exp_pay(30, 512);
    send(-1, -1, PAY0 + 30, 1'b0);
    check("drop_after_reset", 48'(drop_cnt), 48'd0);
    build(LMAC, 16'h0800, LIP, LPORT, 64, 72);
    exp_pay(64, 64); exp_done(1'b1);
    send(-1, -1, -1, 1'b0);
    check("drop_post_reset_good", 48'(drop_cnt), 48'd0);

    repeat (10) @(posedge sys_clk);
    #1;
    check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Byte-wide Ethernet/IPv4/UDP receive parser between the RGMII-to-GMII DDR converter and the payload write buffer that feeds DDR3 in TxTop.
- Strips preamble, SFD and headers, filters on local MAC, IP and port, and streams UDP payload bytes.
- Checks the frame FCS and reports a per-packet good/bad verdict so the downstream buffer can commit or roll back.
- ARP frames are not handled here; they are rejected silently and counted.

Parameters:
LOCAL_MAC, 48'h112233445566, destination MAC to accept
LOCAL_IP, 32'hC0A80180, destination IPv4 address to accept (192.168.1.128)
LOCAL_PORT, 16'd1234, destination UDP port to accept
CNT_W, 16, width of the dropped-frame counter

Ports:
sys_clk  in  1  125 MHz GMII receive clock (rgmii_rxc-derived at top level)
sys_rst_n  in  1  asynchronous active-low reset
gmii_rx_dv  in  1  receive data valid
gmii_rx_er  in  1  receive error
gmii_rxd  in  8  receive byte
udp_data  out  8  payload byte
udp_valid  out  1  payload byte strobe
udp_sof  out  1  first payload byte, coincident with udp_valid
udp_eof  out  1  last payload byte, coincident with udp_valid
udp_len  out  16  payload length (UDP length - 8); valid from udp_sof until the next packet
pkt_done  out  1  one-cycle end-of-packet strobe
pkt_ok  out  1  verdict, qualified by pkt_done
drop_cnt  out  CNT_W  saturating count of rejected frames

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous, active-low (sys_rst_n).
- Reset values: all outputs 0; FSM in IDLE; CRC register all ones.
- FSM states:
  - IDLE: on dv=1 with 0x55, go to PREAMBLE.
  - PREAMBLE: accept 1-7 bytes of 0x55, then 0xD5 goes to ETH_HDR; any other byte goes to DROP.
  - ETH_HDR: 14 bytes. Dest MAC must equal LOCAL_MAC and EtherType must be 0x0800, else DROP.
  - IP_HDR: 20 bytes. Byte0 must be 0x45, protocol 17, dest IP == LOCAL_IP, else DROP. Any other IHL goes to DROP.
  - UDP_HDR: 8 bytes. Dest port == LOCAL_PORT and UDP length >= 8, else DROP. If length == 8, go to TRAIL.
  - PAYLOAD: emit udp_len bytes.
  - TRAIL: consume pad and FCS until dv=0.
  - DROP: wait for dv=0, increment drop_cnt, return to IDLE.
- Latency: udp_data, udp_valid, udp_sof and udp_eof are registered, 1 cycle after the byte appears on gmii_rxd.
- CRC: reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF) over every byte from dest MAC through FCS. The frame is good when the register equals 0xDEBB20E3 at dv fall.
- End of packet: pkt_done is asserted 1 cycle after dv falls, and only for frames that issued udp_sof.
  - pkt_ok = CRC good AND no rx_er seen AND all payload bytes received AND at least 4 trailing bytes seen.
  - A bad packet also increments drop_cnt.
- Boundary conditions:
  - rx_er at any time: frame marked bad. Before sof it goes to DROP; after sof streaming continues and pkt_ok=0.
  - dv falls before udp_eof: no udp_eof is issued; pkt_done with pkt_ok=0.
  - dv falls in ETH_HDR, IP_HDR or UDP_HDR: counted as a drop, no pkt_done.
  - Pad bytes (short payload, e.g. 3 bytes plus 15 pad): never emitted.
  - Bytes beyond the Ethernet minimum: ignored, but still included in the CRC.
  - dv must be low for at least 1 cycle between frames. dv=1 in IDLE with a byte other than 0x55: the block ignores the frame until dv falls, and does not count it.
  - drop_cnt saturates at all ones.
  - Reset mid-frame: outputs cleared immediately; the rest of that frame is ignored until dv falls.

Optional Feature:
IP_CSUM_CHECK_EN
- Defined: compute the 16-bit ones-complement sum over the 20 IP header bytes. If the result is not 0xFFFF at the end of IP_HDR, go to DROP and count the frame.
- Undefined: the checksum field is ignored and the summing logic is absent.

Decomposition:
- Package udp_rx_pkg holds:
  - state enum;
  - ETH_TYPE_IPV4=16'h0800;
  - IP_PROTO_UDP=8'd17;
  - PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5;
  - CRC_RESIDUE=32'hDEBB20E3;
  - header byte counts 14/20/8.
- Sub-module crc32_d8: 8-bit-parallel reflected CRC-32 next-state logic with init and enable inputs.

Test Plan:
- Good 512-byte UDP frame to 11:22:33:44:55:66 / 192.168.1.128:1234, FCS 0x9270C69F -> 512 valids with data 0x00..0xFF repeating, sof on the first, eof on the last, udp_len=512, pkt_done with pkt_ok=1, drop_cnt=0.
- 3-byte payload with 15 pad bytes, FCS 0xCF1C7C69 -> exactly 3 valids (0,1,2), udp_len=3, pkt_ok=1.
- 64-byte frame with one payload byte corrupted -> 64 valids, pkt_done with pkt_ok=0, drop_cnt increments by 1.
- ARP broadcast frame, then UDP to 192.168.1.129 -> no udp_valid, no pkt_done, drop_cnt=2.
- dv deasserted 100 bytes into a 512-byte payload -> 100 valids, no eof, pkt_done with pkt_ok=0. A following good frame parses correctly.
- sys_rst_n pulsed mid-payload -> outputs 0 immediately, no pkt_done for that frame. The next frame is received with pkt_ok=1.
